axi_motor_pwm_array: RTL and testbench

AXI4-Lite slave driving NUM_CH motor PWM/direction channel pairs from a shared period counter. It is the multi-channel successor to the single-register-bank motor IP. Software stages duty/direction per channel and a shared period. A load request commits all staged values atomically at the next PWM period boundary, with dead-time insertion on direction reversal. It sits between the PS AXI interconnect and the PMOD motor driver pins.

---
 rtl/axi_motor_pwm_array.sv | 160 ++++++++++++++++
 tb/tb_axi_motor_pwm_array.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_motor_pwm_array.sv
// Multi-channel motor PWM/direction generator behind an AXI4-Lite slave.
// Staged duty/dir/period commit atomically at a period boundary, with dead-time on reversal.
module axi_motor_pwm_array #(
    parameter int NUM_CH             = 2,
    parameter int PWM_WIDTH          = 16,
    parameter int DEAD_CYCLES        = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [NUM_CH-1:0]             pwm,
    output logic [NUM_CH-1:0]             dir,
    output logic                          period_tick
);

    localparam logic [31:0] DEAD_LEN = 32'(DEAD_CYCLES);
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    logic                 en, load_pending;
    logic [PWM_WIDTH-1:0] period_stg, period_act, cnt;
    logic [PWM_WIDTH-1:0] duty_stg [NUM_CH];
    logic [PWM_WIDTH-1:0] duty_act [NUM_CH];
    logic [NUM_CH-1:0]    dir_stg, dir_act, dead_flag;

    logic        wr_fire, rd_fire, wrap, commit;
    logic [31:0] wr_word, rd_word;

    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction

    function automatic logic is_mapped(input logic [31:0] w);
        return (w <= 32'd2) || ((w >= 32'd4) && (w < 32'(NUM_CH + 4)));
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        if (w == 32'd0) r[0] = en;
        if (w == 32'd1) r[PWM_WIDTH-1:0] = period_stg;
        if (w == 32'd2) r = {8'd0, 8'(PWM_WIDTH), 4'd0, 4'(NUM_CH), 7'd0, load_pending};
        for (int n = 0; n < NUM_CH; n++) begin
            if (w == 32'(n + 4)) r = {dir_stg[n], 31'(duty_stg[n])};
        end
        return r;
    endfunction

    always_comb begin
        wr_fire = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
        rd_fire = s_axi_arready && s_axi_arvalid;
        wr_word = 32'(s_axi_awaddr >> 2);
        rd_word = 32'(s_axi_araddr >> 2);
        wrap    = en && (cnt == period_act);
        commit  = load_pending && (wrap || !en);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= OKAY;
            en            <= 1'b0;
            load_pending  <= 1'b0;
            period_stg    <= '0;
            period_act    <= '0;
            cnt           <= '0;
            dir_stg       <= '0;
            dir_act       <= '0;
            dead_flag     <= '0;
            pwm           <= '0;
            dir           <= '0;
            period_tick   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_stg[n] <= '0;
                duty_act[n] <= '0;
            end
        end else begin
            // AXI write channel: one-cycle ready pulse, response held until accepted
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= is_mapped(wr_word) ? OKAY : SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            // AXI read channel
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= read_word(rd_word);
                s_axi_rresp  <= is_mapped(rd_word) ? OKAY : SLVERR;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end

            // Staged register writes; commit below samples the pre-write staged values
            if (wr_fire) begin
                if (wr_word == 32'd0) en <= s_axi_wstrb[0] ? s_axi_wdata[0] : en;
                if (wr_word == 32'd1)
                    period_stg <= PWM_WIDTH'(merge_strb(32'(period_stg), s_axi_wdata, s_axi_wstrb));
                for (int n = 0; n < NUM_CH; n++) begin
                    if (wr_word == 32'(n + 4)) begin
                        duty_stg[n] <= PWM_WIDTH'(merge_strb(32'(duty_stg[n]), s_axi_wdata, s_axi_wstrb));
                        dir_stg[n]  <= s_axi_wstrb[3] ? s_axi_wdata[31] : dir_stg[n];
                    end
                end
            end
            load_pending <= (load_pending && !commit) ||
                            (wr_fire && (wr_word == 32'd0) && s_axi_wstrb[0] && s_axi_wdata[1]);

            if (commit) begin
                period_act <= period_stg;
                dir_act    <= dir_stg;
                dead_flag  <= dir_stg ^ dir_act;
                for (int n = 0; n < NUM_CH; n++) duty_act[n] <= duty_stg[n];
            end else if (wrap) begin
                dead_flag <= '0;
            end

            if (!en || wrap) cnt <= '0;
            else             cnt <= cnt + 1'b1;

            // Output stage: registered view of the current count and active state
            for (int n = 0; n < NUM_CH; n++) begin
                pwm[n] <= en && (cnt < duty_act[n]) && !(dead_flag[n] && (32'(cnt) < DEAD_LEN));
            end
            dir         <= dir_act;
            period_tick <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_axi_motor_pwm_array.sv
// Directed bench for axi_motor_pwm_array: register map, PWM timing, staged commit, dead-time, reset.
module tb_axi_motor_pwm_array;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, period_tick;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [1:0]    pwm, dir;

    int vectors = 0;
    int miscompares = 0;

    axi_motor_pwm_array #(
        .NUM_CH(2), .PWM_WIDTH(16), .DEAD_CYCLES(4), .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .pwm(pwm), .dir(dir), .period_tick(period_tick)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin step(); n++; end
        if (!awready) begin
            vectors++; miscompares++;
            $display("FAIL write_awready_timeout addr=%h", a);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        if (!bvalid) begin
            vectors++; miscompares++;
            $display("FAIL write_bvalid_timeout addr=%h", a);
        end
        resp = bresp;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        if (!arready) begin
            vectors++; miscompares++;
            $display("FAIL read_arready_timeout addr=%h", a);
        end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        if (!rvalid) begin
            vectors++; miscompares++;
            $display("FAIL read_rvalid_timeout addr=%h", a);
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        step();
        n = 0;
        while (!period_tick && n < 60) begin step(); n++; end
        if (!period_tick) begin
            vectors++; miscompares++;
            $display("FAIL period_tick_timeout");
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        reset = 1'b1;
        step(3);
        vectors++;
        if ({pwm, dir, period_tick, bvalid, rvalid, awready, arready} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=0", {pwm, dir, period_tick, bvalid, rvalid, awready, arready});
        end
        reset = 1'b0;
        step();
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h0010_0200 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL status_read got=%h/%b want=00100200/00", d, r);
        end
        axi_read(8'h40, d, r);
        vectors++;
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_read_40 got=%h/%b want=00000000/10", d, r);
        end
        axi_read(8'h0C, d, r);
        vectors++;
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_read_0c got=%h/%b want=00000000/10", d, r);
        end
        axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, r);
        vectors++;
        if (r !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_write_resp got=%b want=10", r);
        end
        axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h0010_0200 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL status_write_ignored got=%h/%b want=00100200/00", d, r);
        end
    endtask

    task automatic test_basic_pwm();
        logic [1:0] r;
        axi_write(8'h04, 32'd9, 4'hF, r);
        vectors++;
        if (r !== 2'b00) begin
            miscompares++;
            $display("FAIL period_write_resp got=%b want=00", r);
        end
        axi_write(8'h10, 32'd3, 4'hF, r);
        axi_write(8'h14, 32'd10, 4'hF, r);
        axi_write(8'h00, 32'h3, 4'hF, r);
        step(2);
        wait_tick();
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (pwm[0] !== ((i % 10) < 3) || pwm[1] !== 1'b1 || period_tick !== ((i % 10) == 0)) begin
                miscompares++;
                $display("FAIL basic_pwm i=%0d got pwm=%b tick=%b want pwm0=%b pwm1=1 tick=%b",
                         i, pwm, period_tick, (i % 10) < 3, (i % 10) == 0);
            end
            step();
        end
    endtask

    task automatic test_staged_reload();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h10, 32'd7, 4'hF, r);
        wait_tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (pwm[0] !== (i < 3)) begin
                miscompares++;
                $display("FAIL staged_no_effect i=%0d got=%b want=%b", i, pwm[0], i < 3);
            end
            step();
        end
        axi_write(8'h00, 32'h3, 4'hF, r);
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h0010_0201) begin
            miscompares++;
            $display("FAIL load_pending_set got=%h want=00100201", d);
        end
        wait_tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (pwm[0] !== (i < 7) || period_tick !== (i == 0)) begin
                miscompares++;
                $display("FAIL reload_duty7 i=%0d got pwm0=%b tick=%b want %b/%b",
                         i, pwm[0], period_tick, i < 7, i == 0);
            end
            step();
        end
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h0010_0200) begin
            miscompares++;
            $display("FAIL load_pending_clear got=%h want=00100200", d);
        end
    endtask

    task automatic test_dead_time();
        logic [1:0] r;
        int n;
        axi_write(8'h10, 32'h8000_0008, 4'hF, r);
        axi_write(8'h00, 32'h3, 4'hF, r);
        n = 0;
        while (!dir[0] && n < 60) begin step(); n++; end
        vectors++;
        if (dir[0] !== 1'b1 || period_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL dir_rise_with_tick got dir0=%b tick=%b want 1/1", dir[0], period_tick);
        end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (pwm[0] !== ((i < 10) ? (i >= 4 && i < 8) : ((i - 10) < 8)) || dir[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL dead_time i=%0d got pwm0=%b dir0=%b want pwm0=%b dir0=1",
                         i, pwm[0], dir[0], (i < 10) ? (i >= 4 && i < 8) : ((i - 10) < 8));
            end
            step();
        end
    endtask

    task automatic test_wstrb_and_bhold();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        axi_write(8'h14, 32'h0000_1234, 4'hF, r);
        axi_write(8'h14, 32'hFFFF_FFAA, 4'b0001, r);
        axi_read(8'h14, d, r);
        vectors++;
        if (d !== 32'h0000_12AA || r !== 2'b00) begin
            miscompares++;
            $display("FAIL wstrb_merge got=%h/%b want=000012AA/00", d, r);
        end
        awaddr = 8'h04; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin step(); n++; end
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                miscompares++;
                $display("FAIL bready_hold i=%0d got bvalid=%b awready=%b want 1/0", i, bvalid, awready);
            end
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step();
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL bvalid_release got=%b want=0", bvalid);
        end
    endtask

    task automatic test_reset_midread();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        araddr = 8'h00; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        step();
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || dir[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_state got rvalid=%b dir0=%b want 1/1", rvalid, dir[0]);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (rvalid !== 1'b0 || pwm !== 2'b00 || dir !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_midread got rvalid=%b pwm=%b dir=%b want 0/00/00", rvalid, pwm, dir);
        end
        reset = 1'b0;
        step();
        for (int a = 0; a < 4; a++) begin
            logic [AW-1:0] addr;
            addr = (a == 0) ? 8'h00 : (a == 1) ? 8'h04 : (a == 2) ? 8'h10 : 8'h14;
            axi_read(addr, d, r);
            vectors++;
            if (d !== 32'h0 || r !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset_read addr=%h got=%h/%b want=00000000/00", addr, d, r);
            end
        end
        axi_read(8'h08, d, r);
        vectors++;
        if (d !== 32'h0010_0200) begin
            miscompares++;
            $display("FAIL post_reset_status got=%h want=00100200", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_staged_reload();
        test_dead_time();
        test_wstrb_and_bhold();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
